// File: rtl/nf_cf_compress_stage_pkg.sv
// Shared constants, the share-vector type and index helpers for the masked S-box
// compression stage.
package nf_cf_compress_stage_pkg;

  localparam int SHARES       = 3;
  localparam int CF_PER_BIT   = 9;
  localparam int CF_PER_SHARE = CF_PER_BIT / SHARES;
  localparam int RND_PER_BIT  = 2;

  // One coordinate's worth of output shares, bit s = share s+1.
  typedef logic [SHARES-1:0] share_vec_t;

  // First component-function bit feeding share s (0-based) of coordinate n.
  function automatic int cf_base(input int n, input int s);
    return CF_PER_BIT * n + CF_PER_SHARE * s;
  endfunction

  // Position of share s (0-based) of coordinate n in the packed share bus.
  function automatic int sh_idx(input int n, input int s);
    return SHARES * n + s;
  endfunction

endpackage

// File: rtl/nf_cf_compress_stage_cf_group_xor.sv
// cf_group_xor: folds one group of component-function bits into a single share bit.
// Purely combinational; it only ever sees bits that belong to one d share.
module cf_group_xor
  import nf_cf_compress_stage_pkg::*;
(
  input  logic [CF_PER_SHARE-1:0] cf_bits,
  output logic                    share_bit
);

  assign share_bit = ^cf_bits;

endmodule

// File: rtl/nf_cf_compress_stage.sv
// nf_cf_compress_stage: two-stage pipeline behind the masked S-box component functions.
// Stage 1 registers the raw component bits (glitch barrier), stage 2 registers the
// XOR-compressed output shares.
// Optional feature macro: SBOX_REMASK_EN adds the rnd port and re-masks the shares
// with fresh randomness on every stage-2 load.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
// A producer keeps valid and data stable until it transfers; this stage keeps
// out_valid and out_sh stable while out_valid=1 and out_ready=0.
module nf_cf_compress_stage
  import nf_cf_compress_stage_pkg::*;
#(
  parameter int N_BITS = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CF_PER_BIT*N_BITS-1:0] cf_in,
`ifdef SBOX_REMASK_EN
  input  logic [RND_PER_BIT*N_BITS-1:0] rnd,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SHARES*N_BITS-1:0]     out_sh,
  output logic                         busy
);

  localparam int CW = CF_PER_BIT * N_BITS;
  localparam int SW = SHARES * N_BITS;

  logic          s1_valid_q, s1_valid_d;
  logic [CW-1:0] s1_data_q,  s1_data_d;
  logic          s2_valid_q, s2_valid_d;
  logic [SW-1:0] out_sh_q,   out_sh_d;

  logic          s1_adv;
  logic          s1_open;
  logic [SW-1:0] comp_sh;
  logic [SW-1:0] sh_next;

  // Compression reads only the registered stage-1 bits, one instance per share bit.
  for (genvar n = 0; n < N_BITS; n++) begin : g_coord
    for (genvar s = 0; s < SHARES; s++) begin : g_share
      cf_group_xor u_grp (
        .cf_bits   (s1_data_q[cf_base(n, s) +: CF_PER_SHARE]),
        .share_bit (comp_sh[sh_idx(n, s)])
      );
    end
  end

`ifdef SBOX_REMASK_EN
  // Re-mask each coordinate; the three mask bits XOR to zero so the secret is unchanged.
  always_comb begin
    sh_next = comp_sh;
    for (int n = 0; n < N_BITS; n++) begin
      share_vec_t m;
      m = {rnd[2*n] ^ rnd[2*n+1], rnd[2*n+1], rnd[2*n]};
      sh_next[SHARES*n +: SHARES] = comp_sh[SHARES*n +: SHARES] ^ m;
    end
  end
`else
  assign sh_next = comp_sh;
`endif

  assign s1_adv   = !s2_valid_q || out_ready;
  assign s1_open  = !s1_valid_q || s1_adv;
  assign in_ready = !flush && s1_open;

  // Next-state for both stages; flush clears everything and blocks new input.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s2_valid_d = s2_valid_q;
    out_sh_d   = out_sh_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s1_data_d  = '0;
      s2_valid_d = 1'b0;
      out_sh_d   = '0;
    end else begin
      if (s1_open) begin
        s1_valid_d = in_valid;
        if (in_valid) s1_data_d = cf_in;
      end
      if (s1_adv) begin
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) out_sh_d = sh_next;
      end
    end
  end

  // Pipeline registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      out_sh_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      out_sh_q   <= out_sh_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_sh    = out_sh_q;
  assign busy      = s1_valid_q || s2_valid_q;

endmodule
